// File: rtl/count_seq_monitor.sv
// Sequence monitor for an upstream 3-bit counter: checks Y against the value implied by
// the previous sample, flags wraps 7->0, counts them and measures the wrap period.
// Optional build macro: WRAP_SAT_EN (wrap_cnt saturates at 255 instead of rolling over).
module count_seq_monitor (
    input  logic       clk,
    input  logic       reset,
    input  logic       T0,
    input  logic [2:0] Y,
    input  logic       err_clr,
    output logic       tc_pulse,
    output logic [7:0] wrap_cnt,
    output logic [7:0] last_period,
    output logic       seq_err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ERROR = 2'b10
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] y_q;
    logic       t_q;
    logic [2:0] expected;
    logic       mismatch;
    logic       wrap_evt;
    logic       armed;
    logic [7:0] period_cnt;
    logic [7:0] wrap_cnt_nxt;

    assign expected = t_q ? (y_q + 3'd1) : y_q;
    assign state    = state_q;

`ifdef WRAP_SAT_EN
    assign wrap_cnt_nxt = (wrap_cnt == 8'hFF) ? wrap_cnt : (wrap_cnt + 8'd1);
`else
    assign wrap_cnt_nxt = wrap_cnt + 8'd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // err_clr overrides any same-cycle mismatch or wrap and resynchronises via IDLE.
    always_comb begin
        state_d  = state_q;
        mismatch = 1'b0;
        wrap_evt = 1'b0;
        case (state_q)
            IDLE:  state_d = TRACK;
            TRACK: begin
                if (Y != expected) begin
                    mismatch = 1'b1;
                    state_d  = ERROR;
                end else if (t_q && (y_q == 3'd7) && (Y == 3'd0)) begin
                    wrap_evt = 1'b1;
                end
            end
            ERROR: state_d = ERROR;
            default: state_d = IDLE;
        endcase
        if (err_clr) begin
            state_d  = IDLE;
            mismatch = 1'b0;
            wrap_evt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q         <= 3'd0;
            t_q         <= 1'b0;
            tc_pulse    <= 1'b0;
            wrap_cnt    <= 8'd0;
            last_period <= 8'd0;
            seq_err     <= 1'b0;
            armed       <= 1'b0;
            period_cnt  <= 8'd0;
        end else begin
            y_q      <= Y;
            t_q      <= T0;
            tc_pulse <= wrap_evt;

            if (err_clr)       seq_err <= 1'b0;
            else if (mismatch) seq_err <= 1'b1;

            if (wrap_evt) wrap_cnt <= wrap_cnt_nxt;

            // The first wrap after IDLE only arms the period measurement.
            if (wrap_evt) begin
                if (armed) last_period <= period_cnt;
                armed      <= 1'b1;
                period_cnt <= 8'd1;
            end else if (state_q == IDLE) begin
                armed      <= 1'b0;
                period_cnt <= 8'd0;
            end else if (armed && (period_cnt != 8'hFF)) begin
                period_cnt <= period_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor: counting, frozen counter, sequence errors,
// err_clr priority, mid-run reset, period saturation and 300-wrap overflow.
module tb_count_seq_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       T0 = 1'b0;
    logic [2:0] Y = 3'd0;
    logic       err_clr = 1'b0;
    logic       tc_pulse;
    logic [7:0] wrap_cnt;
    logic [7:0] last_period;
    logic       seq_err;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    count_seq_monitor dut (
        .clk(clk), .reset(reset), .T0(T0), .Y(Y), .err_clr(err_clr),
        .tc_pulse(tc_pulse), .wrap_cnt(wrap_cnt), .last_period(last_period),
        .seq_err(seq_err), .state(state)
    );

    always #5 clk = ~clk;

    // One clock edge; afterwards Y advances like the upstream counter driven by T0.
    task automatic step();
        @(posedge clk);
        #1;
        Y = Y + {2'b00, T0};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic t0_val, input logic [2:0] y_val);
        reset = 1'b1; err_clr = 1'b0; T0 = t0_val;
        step();
        reset = 1'b0; Y = y_val;
    endtask

    initial begin
        int pulses;
        logic err_seen;
        logic found;
        logic [7:0] exp_wraps;

        // Reset state
        do_reset(1'b0, 3'd0);
        chk("rst_tc", tc_pulse, 0);
        chk("rst_wrap", wrap_cnt, 0);
        chk("rst_lp", last_period, 0);
        chk("rst_err", seq_err, 0);
        chk("rst_state", state, 2'b00);

        // Free counting: wraps at edges 9, 17, 25
        T0 = 1'b1; Y = 3'd0;
        for (int i = 1; i <= 25; i++) begin
            step();
            chk($sformatf("cnt_tc_%0d", i), tc_pulse, (i == 9 || i == 17 || i == 25));
            if (i == 1) chk("cnt_state_track", state, 2'b01);
            if (i == 9) begin
                chk("cnt_wrap1", wrap_cnt, 1);
                chk("cnt_lp_first", last_period, 0);
            end
            if (i == 17) begin
                chk("cnt_wrap2", wrap_cnt, 2);
                chk("cnt_lp2", last_period, 8);
            end
        end
        chk("cnt_wrap3", wrap_cnt, 3);
        chk("cnt_lp3", last_period, 8);
        chk("cnt_err", seq_err, 0);

        // Reset in the middle of operation, then restart counting
        reset = 1'b1;
        step();
        chk("mid_rst_tc", tc_pulse, 0);
        chk("mid_rst_wrap", wrap_cnt, 0);
        chk("mid_rst_lp", last_period, 0);
        chk("mid_rst_err", seq_err, 0);
        chk("mid_rst_state", state, 2'b00);
        reset = 1'b0; Y = 3'd0; T0 = 1'b1;
        for (int i = 1; i <= 9; i++) step();
        chk("restart_tc", tc_pulse, 1);
        chk("restart_wrap", wrap_cnt, 1);
        chk("restart_lp", last_period, 0);

        // Frozen counter: T0=0, Y=5 for 50 cycles
        do_reset(1'b0, 3'd5);
        pulses = 0; err_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tc_pulse) pulses++;
            err_seen |= seq_err;
        end
        chk("frz_pulses", pulses, 0);
        chk("frz_err", err_seen, 0);
        chk("frz_state", state, 2'b01);

        // Sequence error 3->5, ERROR holds and ignores a 7->0 pattern
        do_reset(1'b1, 3'd0);
        for (int i = 1; i <= 4; i++) step();
        Y = 3'd5;
        step();
        chk("seq_state_err", state, 2'b10);
        chk("seq_err_set", seq_err, 1);
        step(); step(); step();
        chk("err_state_hold", state, 2'b10);
        chk("err_no_tc", tc_pulse, 0);
        chk("err_no_wrap", wrap_cnt, 0);
        chk("err_sticky", seq_err, 1);
        err_clr = 1'b1;
        step();
        chk("clr_state_idle", state, 2'b00);
        chk("clr_err", seq_err, 0);
        err_clr = 1'b0;
        step();
        chk("clr_state_track", state, 2'b01);
        chk("clr_err_track", seq_err, 0);
        step();
        chk("clr_err_stays", seq_err, 0);

        // err_clr on the same edge as a mismatch
        Y = 3'd6; err_clr = 1'b1;
        step();
        chk("prio_state", state, 2'b00);
        chk("prio_err", seq_err, 0);
        err_clr = 1'b0;
        step();
        step();
        chk("resync_tc", tc_pulse, 1);
        chk("resync_wrap", wrap_cnt, 1);
        chk("resync_lp", last_period, 0);
        err_clr = 1'b1;
        step();
        chk("keep_wrap", wrap_cnt, 1);
        chk("keep_tc_one", tc_pulse, 0);
        err_clr = 1'b0;

        // Period saturation at 255
        do_reset(1'b1, 3'd0);
        for (int i = 1; i <= 9; i++) step();
        T0 = 1'b0;
        for (int i = 0; i < 300; i++) step();
        T0 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            step();
            if (tc_pulse) found = 1'b1;
        end
        chk("sat_found", found, 1);
        chk("sat_lp", last_period, 255);
        chk("sat_wrap", wrap_cnt, 2);
        chk("sat_err", seq_err, 0);

        // 300 wraps
        do_reset(1'b1, 3'd0);
        pulses = 0;
        for (int i = 0; i < 1 + 8 * 300; i++) begin
            step();
            if (tc_pulse) pulses++;
        end
`ifdef WRAP_SAT_EN
        exp_wraps = 8'd255;
`else
        exp_wraps = 8'd44;
`endif
        chk("w300_pulses", pulses, 300);
        chk("w300_wrap", wrap_cnt, exp_wraps);
        chk("w300_lp", last_period, 8);
        chk("w300_err", seq_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_seq_monitor.md
COUNT_SEQ_MONITOR -- requirements
Module: count_seq_monitor

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port T0, input, 1 bit: count enable, the same signal driven to the upstream 3-bit counter.
REQ-004 The block SHALL have port Y, input, 3 bits: count value from the upstream counter.
REQ-005 The block SHALL have port err_clr, input, 1 bit: clears the sequence error and resynchronises the monitor.
REQ-006 The block SHALL have port tc_pulse, output, 1 bit: one-cycle terminal-count (wrap 7->0) pulse.
REQ-007 The block SHALL have port wrap_cnt, output, 8 bits: number of wraps detected since reset.
REQ-008 The block SHALL have port last_period, output, 8 bits: clock cycles between the two most recent wraps.
REQ-009 The block SHALL have port seq_err, output, 1 bit: sticky sequence-error flag.
REQ-010 The block SHALL have port state, output, 2 bits: FSM state encoding, IDLE=00, TRACK=01, ERROR=10.

Function
REQ-011 The block SHALL register y_q (Y) and t_q (T0) every cycle; these are the previous-edge samples.
REQ-012 The block SHALL define expected = (y_q + 1) mod 8 when t_q=1 and expected = y_q when t_q=0, using 3-bit wrap-around arithmetic.
REQ-013 In IDLE, the block SHALL capture y_q/t_q, perform no check, and go to TRACK on the next cycle.
REQ-014 In TRACK, when Y != expected, the block SHALL go to ERROR and set seq_err=1 on that same edge.
REQ-015 In TRACK, when t_q=1, y_q=7 and Y=0, the block SHALL assert tc_pulse for exactly the one cycle after that edge.
REQ-016 On each tc_pulse assertion, the block SHALL increment wrap_cnt by 1 (overflow per REQ-024/025).
REQ-017 The block SHALL count cycles since the previous wrap in an 8-bit period counter that saturates at 255.
REQ-018 On each wrap, the block SHALL load the period count into last_period and restart the count at 1.
REQ-019 Only after the first wrap following IDLE, the block SHALL leave last_period unchanged and only start the period count.
REQ-020 In ERROR, the block SHALL hold seq_err=1, detect no wraps and keep tc_pulse=0; it SHALL leave ERROR only via err_clr or reset.
REQ-021 When err_clr=1 in any state, the block SHALL go to IDLE and clear seq_err; err_clr SHALL win over a same-cycle mismatch, leaving seq_err=0.
REQ-022 The block SHALL NOT clear wrap_cnt or last_period on err_clr.

Reset
REQ-023 On a clk edge with reset=1, the block SHALL enter IDLE with tc_pulse=0, wrap_cnt=0, last_period=0, seq_err=0, period count 0 and y_q=0, t_q=0; this includes a reset in the middle of operation.

Configuration
REQ-024 With WRAP_SAT_EN defined, wrap_cnt SHALL saturate at 255 and further wraps SHALL leave it at 255; tc_pulse is still generated.
REQ-025 Without WRAP_SAT_EN, wrap_cnt SHALL roll over from 255 to 0.

Verification
REQ-026 The bench SHALL apply reset for 1 cycle, then T0=1 continuously with Y as a true counter -> tc_pulse once every 8 cycles, wrap_cnt=1,2,3, last_period=8 after the 2nd wrap, seq_err=0.
REQ-027 The bench SHALL hold T0=0 with Y frozen at 5 for 50 cycles -> no tc_pulse, seq_err=0, state=TRACK.
REQ-028 The bench SHALL, with T0=1, force Y 3->5 -> seq_err=1 and state=ERROR after that edge; then pulse err_clr -> IDLE, then TRACK, seq_err=0.
REQ-029 The bench SHALL drive err_clr=1 on the same cycle as a mismatch -> state=IDLE and seq_err stays 0.
REQ-030 The bench SHALL produce 300 wraps -> wrap_cnt=255 with WRAP_SAT_EN, wrap_cnt=44 without it.
REQ-031 The bench SHALL assert reset after wrap_cnt=3 -> all outputs 0 and IDLE on the next edge, and the count restarts correctly.
